// File: rtl/alias_bus_arbiter_if.sv
// Bus bundle between the alias-bus arbiter and its requesters / bus sink.
// Handshake: a word moves on an edge where bus_valid && bus_ready; ack marks that word.
interface alias_bus_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  bus_ready;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  bus_valid;
    logic [WIDTH-1:0]      bus_data;
    logic [OW-1:0]         bus_owner;
    logic                  dbg_own;

    modport master (
        input  req, req_data, bus_ready,
        output gnt, ack, bus_valid, bus_data, bus_owner, dbg_own
    );

    modport slave (
        output req, req_data, bus_ready,
        input  gnt, ack, bus_valid, bus_data, bus_owner, dbg_own
    );
endinterface

// File: rtl/alias_bus_arbiter.sv
// Round-robin owner selection for a shared aliased bus: one requester at a time
// drives bus_data for a burst of up to MAX_BURST accepted words.
module alias_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alias_bus_arbiter_if.master  bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [OW-1:0] PTR_RST  = OW'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic             any_req;
    logic             win_found;
    logic [OW-1:0]    win_idx;
    logic             own_req;
    logic [WIDTH-1:0] own_data;
    logic             own_valid;
    logic             xfer;
    logic             rearb;

    // The pointer always equals the current owner while in ST_OWN, so it
    // doubles as the owner index and as the round-robin start point.
    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ptr_q == OW'(i)) begin
                own_req  = bus.req[i];
                own_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        own_valid = (state_q == ST_OWN) && own_req;
        xfer      = own_valid && bus.bus_ready;
    end

    // Scan from ptr+1 wrapping round; the current owner is visited last.
    always_comb begin
        int idx;
        any_req   = |bus.req;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        rearb   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rearb = any_req;
            end
            ST_OWN: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!own_req || (xfer && (cnt_q == CNT_LAST))) begin
                    rearb = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Release and re-grant happen on the same edge, so there is no idle bubble.
        if (rearb) begin
            cnt_d = '0;
            if (win_found) begin
                state_d = ST_OWN;
                ptr_d   = win_idx;
                for (int i = 0; i < NREQ; i++) begin
                    gnt_d[i] = (win_idx == OW'(i));
                end
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_comb begin
        bus.gnt       = gnt_q;
        bus.ack       = '0;
        bus.bus_valid = 1'b0;
        bus.bus_data  = '0;
        bus.bus_owner = '0;
        bus.dbg_own   = (state_q == ST_OWN);
        if (state_q == ST_OWN) begin
            bus.bus_valid = own_valid;
            bus.bus_owner = ptr_q;
            if (own_valid) begin
                bus.bus_data = own_data;
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.ack[i] = xfer && (ptr_q == OW'(i));
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_ack_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.ack & ~gnt_q) == '0));
    a_gnt_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == ST_OWN) == (gnt_q != '0)));

endmodule
